// File: rtl/lut_neuron_pkg.sv
// Shared definitions for the pipelined LUT neuron: controller states, table
// geometry and reset-table entry extraction.
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_e;

  // Widest flattened INIT vector and widest table entry the helpers support.
  localparam int MAX_TABLE_BITS = 4096;
  localparam int MAX_OUT_BITS   = 32;

  // Number of table entries addressed by an IN_BITS-wide lookup address.
  function automatic int depth(input int in_bits);
    return 1 << in_bits;
  endfunction

  // Entry k of a flattened table; the caller truncates to its OUT_BITS width.
  function automatic logic [MAX_OUT_BITS-1:0] init_entry(
    input logic [MAX_TABLE_BITS-1:0] init,
    input int                        k,
    input int                        out_bits
  );
    return MAX_OUT_BITS'(init >> (k * out_bits));
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// Register-based truth table: resets to INIT, one synchronous write port and
// one combinational read port.
module lut_neuron_table
  import lut_neuron_pkg::*;
#(
  parameter int                                 IN_BITS  = 6,
  parameter int                                 OUT_BITS = 1,
  parameter logic [(1<<IN_BITS)*OUT_BITS-1:0]   INIT     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [IN_BITS-1:0]  raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = depth(IN_BITS);
  localparam logic [MAX_TABLE_BITS-1:0] INIT_EXT = MAX_TABLE_BITS'(INIT);

  logic [OUT_BITS-1:0] mem_q [DEPTH];

  // Table storage: reset restores INIT so a partial reload is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= OUT_BITS'(init_entry(INIT_EXT, k, OUT_BITS));
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lut_neuron_pipe.sv
// Pipelined LUT neuron: registered table lookup behind a valid/ready
// handshake, with a serial reload path that first drains the output
// register and then rewrites the whole table in address order.
module lut_neuron_pipe
  import lut_neuron_pkg::*;
#(
  parameter int                                 IN_BITS  = 6,
  parameter int                                 OUT_BITS = 1,
  parameter logic [(1<<IN_BITS)*OUT_BITS-1:0]   INIT     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_busy
);

  localparam int DEPTH = depth(IN_BITS);
  localparam logic [IN_BITS:0] CNT_LAST = (IN_BITS+1)'(DEPTH - 1);
  localparam logic [IN_BITS:0] CNT_ONE  = {{IN_BITS{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [IN_BITS:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] out_data_q, out_data_d;
  logic                cfg_busy_q, cfg_busy_d;
  logic                tbl_we;
  logic [OUT_BITS-1:0] tbl_rdata;
  logic                accept;

  lut_neuron_table #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .INIT    (INIT)
  ) u_table (
    .clk  (clk),
    .rst  (rst),
    .we   (tbl_we),
    .waddr(cnt_q[IN_BITS-1:0]),
    .wdata(cfg_data),
    .raddr(in_data),
    .rdata(tbl_rdata)
  );

  // Lookups are only taken in RUN, and only when the output slot frees up.
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state logic for the output register, reload counter and controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cfg_busy_d  = cfg_busy_q;
    tbl_we      = 1'b0;

    // Output pipeline register: load on accept, empty when consumed.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = tbl_rdata;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      RUN: begin
        // A lookup accepted alongside cfg_start still lands in the output
        // register; if it (or an older word) is still pending, drain first.
        if (cfg_start) begin
          state_d    = out_valid_d ? DRAIN : LOAD;
          cfg_busy_d = 1'b1;
        end
      end
      DRAIN: begin
        if (!out_valid_d) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cfg_valid) begin
          tbl_we = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            state_d    = RUN;
            cfg_busy_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d    = RUN;
        cnt_d      = '0;
        cfg_busy_d = 1'b0;
      end
    endcase
  end

  // Controller, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_busy_q  <= cfg_busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_busy  = cfg_busy_q;

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// Self-checking bench for lut_neuron_pipe: a 6-in/1-out instance tracked by a
// cycle-level behavioural model, plus a 4-in/2-out instance checked directly.
module tb_lut_neuron_pipe;

  localparam logic [63:0] INIT_A = 64'hA5C3_0F4B_96E1_2D70;
  localparam logic [31:0] INIT_B = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A (IN_BITS=6, OUT_BITS=1)
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [5:0] in_data;
  logic [0:0] out_data, cfg_data;
  logic       cfg_start, cfg_valid, cfg_busy;

  // Instance B (IN_BITS=4, OUT_BITS=2)
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [3:0] b_in_data;
  logic [1:0] b_out_data, b_cfg_data;
  logic       b_cfg_start, b_cfg_valid, b_cfg_busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int run_len  = 0;
  int max_run  = 0;

  always #5 clk = ~clk;

  lut_neuron_pipe #(.IN_BITS(6), .OUT_BITS(1), .INIT(INIT_A)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_busy(cfg_busy)
  );

  lut_neuron_pipe #(.IN_BITS(4), .OUT_BITS(2), .INIT(INIT_B)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .cfg_start(b_cfg_start), .cfg_valid(b_cfg_valid), .cfg_data(b_cfg_data),
    .cfg_busy(b_cfg_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model of instance A ----------------
  // m_mode: 0 = serving lookups, 1 = waiting for output to empty, 2 = reloading
  bit m_tbl [64];
  bit m_ov, m_od, m_rdy, m_nov;
  int m_mode, m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) m_tbl[k] = INIT_A[k];
      m_ov = 0; m_od = 0; m_mode = 0; m_cnt = 0;
    end else begin
      m_rdy = (m_mode == 0) && (!m_ov || out_ready);
      m_nov = m_ov;
      if (in_valid && m_rdy) begin
        m_nov = 1;
        m_od  = m_tbl[in_data];
      end else if (out_ready) begin
        m_nov = 0;
      end
      if (m_mode == 0) begin
        if (cfg_start) m_mode = m_nov ? 1 : 2;
      end else if (m_mode == 1) begin
        if (!m_nov) m_mode = 2;
      end else if (cfg_valid) begin
        m_tbl[m_cnt] = cfg_data[0];
        m_cnt = m_cnt + 1;
        if (m_cnt == 64) begin
          m_cnt  = 0;
          m_mode = 0;
        end
      end
      m_ov = m_nov;
    end
  end

  // Every-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready",  {31'd0, in_ready},    {31'd0, (m_mode == 0) && (!m_ov || out_ready)});
      check("out_valid", {31'd0, out_valid},   {31'd0, m_ov});
      check("out_data",  {31'd0, out_data[0]}, {31'd0, m_od});
      check("cfg_busy",  {31'd0, cfg_busy},    {31'd0, m_mode != 0});
    end
  end

  // Longest run of consecutive valid output cycles on instance A.
  always @(negedge clk) begin
    if (rst || !out_valid) run_len = 0;
    else begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end
  end

  initial begin
    in_valid = 0; in_data = '0; out_ready = 1;
    cfg_start = 0; cfg_valid = 0; cfg_data = '0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 1;
    b_cfg_start = 0; b_cfg_valid = 0; b_cfg_data = '0;

    // Reset state
    repeat (3) cyc();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {31'd0, out_data},  32'd0);
    check("rst_cfg_busy",  {31'd0, cfg_busy},  32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_b_busy",    {31'd0, b_cfg_busy}, 32'd0);
    rst = 0;
    cyc();

    // Back-to-back sweep of all addresses
    max_run = 0;
    for (int a = 0; a < 64; a++) begin
      in_valid = 1; in_data = 6'(a);
      cyc();
      if (a == 4)  check("init_0x04", {31'd0, out_data}, 32'd1);
      if (a == 14) check("init_0x0E", {31'd0, out_data}, 32'd0);
      if (a == 38) check("init_0x26", {31'd0, out_data}, 32'd1);
    end
    in_valid = 0;
    cyc();
    check("sweep_valid_run", max_run, 32'd64);

    // Backpressure: hold the word for 0x04
    in_valid = 1; in_data = 6'h04; out_ready = 0;
    cyc();
    in_data = 6'h05;
    repeat (3) begin
      cyc();
      check("stall_data",  {31'd0, out_data}, 32'd1);
      check("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1;
    #1;
    check("release_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    check("release_data_0x05", {31'd0, out_data}, 32'd1);
    in_valid = 0;
    cyc();

    // Reload while the output is stalled: drain, ignored cfg words, load ones
    in_valid = 1; in_data = 6'h26; out_ready = 0;
    cyc();
    in_valid = 0; cfg_start = 1;
    cyc();
    cfg_start = 0;
    check("drain_busy",  {31'd0, cfg_busy}, 32'd1);
    check("drain_ready", {31'd0, in_ready}, 32'd0);
    cfg_valid = 1; cfg_data = 1'b0;
    repeat (2) cyc();
    cfg_valid = 0; out_ready = 1;
    cyc();
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      cfg_valid = 1; cfg_data = 1'b1;
      cyc();
      cfg_valid = 0;
      if (i == 9) begin
        cfg_start = 1;
        cyc();
        cfg_start = 0;
        check("restart_ignored", {31'd0, cfg_busy}, 32'd1);
      end
      if (i == 62) check("busy_before_last", {31'd0, cfg_busy}, 32'd1);
    end
    check("busy_after_last", {31'd0, cfg_busy}, 32'd0);
    in_valid = 1; in_data = 6'h00;
    cyc();
    in_valid = 0;
    check("loaded_0x00", {31'd0, out_data}, 32'd1);
    cyc();

    // Reset in the middle of a reload
    cfg_start = 1;
    cyc();
    cfg_start = 0;
    for (int i = 0; i < 30; i++) begin
      cfg_valid = 1; cfg_data = 1'b1;
      cyc();
    end
    cfg_valid = 0;
    rst = 1;
    #1;
    check("midload_rst_busy",  {31'd0, cfg_busy},  32'd0);
    check("midload_rst_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    rst = 0;
    cyc();
    in_valid = 1; in_data = 6'h00;
    cyc();
    check("after_rst_0x00", {31'd0, out_data}, 32'd0);
    in_data = 6'h04;
    cyc();
    check("after_rst_0x04", {31'd0, out_data}, 32'd1);
    in_valid = 0;
    cyc();

    // Randomised traffic including occasional reloads
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 6'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_start = ($urandom_range(0, 99) == 0);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_data  = 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 0; cfg_start = 0; cfg_valid = 0; out_ready = 1;
    cyc();

    // Instance B: reload table[k] = k mod 4
    b_in_valid = 1; b_in_data = 4'h0;
    cyc();
    b_in_valid = 0;
    check("b_init_0", {30'd0, b_out_data}, 32'd3);
    b_cfg_start = 1;
    cyc();
    b_cfg_start = 0;
    check("b_busy_start", {31'd0, b_cfg_busy}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      b_cfg_valid = 1; b_cfg_data = 2'(k % 4);
      cyc();
    end
    b_cfg_valid = 0;
    check("b_busy_done", {31'd0, b_cfg_busy}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      b_in_valid = 1; b_in_data = 4'(k);
      cyc();
      check("b_lookup_valid", {31'd0, b_out_valid}, 32'd1);
      check("b_lookup_data",  {30'd0, b_out_data}, 32'(k % 4));
    end
    b_in_valid = 0;
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
